updown_mod_counter: RTL and testbench

- Parametrised successor to the team's basic enable counter.
- Counts up or down within a programmable modulus and supports parallel load.
- Selectable wrap or saturate at the count bounds, with terminal-count, wrap-pulse and sticky-overflow status.
- Used as the general-purpose timebase/index counter in datapath and timer blocks.

---
 rtl/updown_mod_counter.sv | 91 +++++++++
 tb/tb_updown_mod_counter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MODULUS-1 with parallel load, wrap or saturate at bounds,
// terminal-count, one-cycle wrap pulse and sticky bound-hit flag.
module updown_mod_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256,
  parameter int RST_VAL = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] DIN,
  input  logic             SAT,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] ctr,
  output logic             TC,
  output logic             WRAP,
  output logic             OVF
);

  // One extra bit so MODULUS = 2**WIDTH yields an all-ones MAX without overflow.
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX   = MAX_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RSTV  = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_ctr;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_ctr_nxt;
  logic [WIDTH-1:0] w_ld_val;
  logic             w_wrap_nxt;
  logic             w_bound;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = ({1'b0, r_ctr} == MAX_X);
  assign w_at_zero = (r_ctr == '0);
  assign w_ld_val  = ({1'b0, DIN} > MAX_X) ? MAX : DIN;

  always_comb begin
    w_ctr_nxt  = r_ctr;
    w_wrap_nxt = 1'b0;
    w_bound    = 1'b0;
    if (LD) begin
      w_ctr_nxt = w_ld_val;
    end else if (EN) begin
      if (UP) begin
        if (w_at_max) begin
          w_bound = 1'b1;
          if (!SAT) begin
            w_ctr_nxt  = '0;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_ctr_nxt = r_ctr + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
          w_bound = 1'b1;
          if (!SAT) begin
            w_ctr_nxt  = MAX;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_ctr_nxt = r_ctr - WIDTH'(1);
        end
      end
    end
  end

  // A bound hit in the same cycle as CLR_OVF keeps the flag set.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_ctr  <= RSTV;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_ctr  <= w_ctr_nxt;
      r_wrap <= w_wrap_nxt;
      r_ovf  <= w_bound | (r_ovf & ~CLR_OVF);
    end
  end

  assign ctr  = r_ctr;
  assign WRAP = r_wrap;
  assign OVF  = r_ovf;
  assign TC   = EN & ~LD & ((UP & w_at_max) | (~UP & w_at_zero));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: expected {ctr,WRAP,OVF,TC} queued with each stimulus step,
// compared against observed values collected 1ns after each rising edge.
module tb_updown_mod_counter;

  typedef struct packed {
    logic [7:0] ctr;
    logic       wrap;
    logic       ovf;
    logic       tc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST, EN, UP, LD, SAT, CLR_OVF;
  logic [7:0] DIN;

  logic [3:0] a_ctr;
  logic       a_tc, a_wrap, a_ovf;
  logic [7:0] b_ctr;
  logic       b_tc, b_wrap, b_ovf;

  exp_t exp_q[$];
  exp_t obs_q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 CLK = ~CLK;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(3)) u_a (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LD(LD), .DIN(DIN[3:0]), .SAT(SAT),
    .CLR_OVF(CLR_OVF), .ctr(a_ctr), .TC(a_tc), .WRAP(a_wrap), .OVF(a_ovf));

  updown_mod_counter #(.WIDTH(8), .MODULUS(256), .RST_VAL(0)) u_b (
    .CLK(CLK), .RST(RST), .EN(EN), .UP(UP), .LD(LD), .DIN(DIN), .SAT(SAT),
    .CLR_OVF(CLR_OVF), .ctr(b_ctr), .TC(b_tc), .WRAP(b_wrap), .OVF(b_ovf));

  function automatic exp_t E(input int c, input bit w, input bit o, input bit t);
    E = '{ctr: 8'(c), wrap: w, ovf: o, tc: t};
  endfunction

  // Drive one cycle of stimulus, queue its expectation, advance, collect the output.
  task automatic step(input bit rst, en, up, ld, sat, clr, input int din,
                      input exp_t e, input bit use_b);
    RST = rst; EN = en; UP = up; LD = ld; SAT = sat; CLR_OVF = clr; DIN = 8'(din);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    if (use_b) obs_q.push_back('{ctr: b_ctr, wrap: b_wrap, ovf: b_ovf, tc: b_tc});
    else       obs_q.push_back('{ctr: {4'h0, a_ctr}, wrap: a_wrap, ovf: a_ovf, tc: a_tc});
  endtask

  task automatic test_reset;
    exp_t e, o;
    // Reset overrides a concurrent load and count.
    step(0, 1, 1, 1, 0, 0, 5, E(3, 0, 0, 0), 0);
    step(0, 1, 1, 1, 0, 0, 5, E(3, 0, 0, 0), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0, 7, E(3, 0, 0, 0), 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL reset: ctr=%0d wrap=%b ovf=%b tc=%b, expected ctr=%0d wrap=%b ovf=%b tc=%b",
                            o.ctr, o.wrap, o.ovf, o.tc, e.ctr, e.wrap, e.ovf, e.tc);
      else passes++;
    end
  endtask

  task automatic test_up_wrap;
    exp_t e, o;
    step(1, 0, 1, 1, 0, 0, 7, E(7, 0, 0, 0), 0);
    step(1, 1, 1, 0, 0, 0, 0, E(8, 0, 0, 0), 0);
    step(1, 1, 1, 0, 0, 0, 0, E(9, 0, 0, 1), 0);
    step(1, 1, 1, 0, 0, 0, 0, E(0, 1, 1, 0), 0);
    step(1, 1, 1, 0, 0, 0, 0, E(1, 0, 1, 0), 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL up_wrap: ctr=%0d wrap=%b ovf=%b tc=%b, expected ctr=%0d wrap=%b ovf=%b tc=%b",
                            o.ctr, o.wrap, o.ovf, o.tc, e.ctr, e.wrap, e.ovf, e.tc);
      else passes++;
    end
  endtask

  task automatic test_down_sat;
    exp_t e, o;
    // Load with CLR_OVF: clear honoured alongside the load.
    step(1, 0, 0, 1, 1, 1, 1, E(1, 0, 0, 0), 0);
    step(1, 1, 0, 0, 1, 0, 0, E(0, 0, 0, 1), 0);
    step(1, 1, 0, 0, 1, 0, 0, E(0, 0, 1, 1), 0);
    step(1, 1, 0, 0, 1, 0, 0, E(0, 0, 1, 1), 0);
    step(1, 0, 0, 0, 1, 1, 0, E(0, 0, 0, 0), 0);
    // Up-saturate at MAX holds and sets OVF.
    step(1, 0, 1, 1, 1, 0, 9, E(9, 0, 0, 0), 0);
    step(1, 1, 1, 0, 1, 0, 0, E(9, 0, 1, 1), 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL down_sat: ctr=%0d wrap=%b ovf=%b tc=%b, expected ctr=%0d wrap=%b ovf=%b tc=%b",
                            o.ctr, o.wrap, o.ovf, o.tc, e.ctr, e.wrap, e.ovf, e.tc);
      else passes++;
    end
  endtask

  task automatic test_load_clamp;
    exp_t e, o;
    step(1, 1, 1, 1, 0, 1, 13, E(9, 0, 0, 0), 0);
    step(1, 1, 1, 0, 0, 0, 13, E(0, 1, 1, 0), 0);
    step(1, 0, 1, 1, 0, 0, 15, E(9, 0, 1, 0), 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL load_clamp: ctr=%0d wrap=%b ovf=%b tc=%b, expected ctr=%0d wrap=%b ovf=%b tc=%b",
                            o.ctr, o.wrap, o.ovf, o.tc, e.ctr, e.wrap, e.ovf, e.tc);
      else passes++;
    end
  endtask

  task automatic test_simultaneous;
    exp_t e, o;
    step(1, 0, 1, 1, 0, 1, 9, E(9, 0, 0, 0), 0);
    step(1, 1, 1, 0, 0, 1, 0, E(0, 1, 1, 0), 0);
    step(0, 1, 1, 1, 0, 0, 6, E(3, 0, 0, 0), 0);
    // Idle: DIN/UP/SAT changes have no effect.
    step(1, 0, 0, 0, 1, 0, 8, E(3, 0, 0, 0), 0);
    step(1, 0, 1, 0, 0, 0, 2, E(3, 0, 0, 0), 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL simultaneous: ctr=%0d wrap=%b ovf=%b tc=%b, expected ctr=%0d wrap=%b ovf=%b tc=%b",
                            o.ctr, o.wrap, o.ovf, o.tc, e.ctr, e.wrap, e.ovf, e.tc);
      else passes++;
    end
  endtask

  task automatic test_full_range;
    exp_t e, o;
    step(1, 0, 0, 1, 0, 1, 0, E(0, 0, 0, 0), 1);
    step(1, 1, 0, 0, 0, 0, 0, E(255, 1, 1, 0), 1);
    // First up-count from 255 wraps to 0; the remaining 254 do not.
    for (int i = 1; i <= 255; i++) step(1, 1, 1, 0, 0, 0, 0, E(i - 1, i == 1, 1, 0), 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) $display("FAIL full_range: ctr=%0d wrap=%b ovf=%b tc=%b, expected ctr=%0d wrap=%b ovf=%b tc=%b",
                            o.ctr, o.wrap, o.ovf, o.tc, e.ctr, e.wrap, e.ovf, e.tc);
      else passes++;
    end
  endtask

  initial begin
    RST = 1'b0; EN = 1'b0; UP = 1'b0; LD = 1'b0; SAT = 1'b0; CLR_OVF = 1'b0; DIN = '0;
    test_reset;
    test_up_wrap;
    test_down_sat;
    test_load_clamp;
    test_simultaneous;
    test_full_range;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
